// File: rtl/store_checker.sv
// store_checker: monitors CPU data-memory stores against a preloaded, ordered list of
// expected stores and reports a sticky pass/fail verdict with the first faulting store.
//
// state | meaning
// LOAD  | accepting expected entries; memwrite ignored
// RUN   | checking stores in order; idle timer armed
// PASS  | every expected store seen; any further store fails
// FAIL  | terminal; all outputs frozen until reset
module store_checker #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 64,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         memwrite_i,
   input  logic [AW-1:0]                dataaddr_i,
   input  logic [DW-1:0]                writedata_i,
   input  logic [31:0]                  pc_i,
   input  logic                         exp_valid_i,
   input  logic [AW-1:0]                exp_addr_i,
   input  logic [DW-1:0]                exp_data_i,
   output logic                         exp_ready_o,
   input  logic                         start_i,
   output logic                         done_o,
   output logic                         pass_o,
   output logic                         fail_o,
   output logic [1:0]                   err_code_o,
   output logic [31:0]                  err_pc_o,
   output logic [AW-1:0]                err_addr_o,
   output logic [DW-1:0]                err_data_o,
   output logic [$clog2(DEPTH+1)-1:0]   match_cnt_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISMATCH = 2'd1;
   localparam logic [1:0] ERR_EXTRA    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_PASS, ST_FAIL} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       count_q, count_d;
   logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       match_cnt_q, match_cnt_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic                pass_q, pass_d;
   logic                fail_q, fail_d;
   logic [1:0]          err_code_q, err_code_d;
   logic [31:0]         err_pc_q, err_pc_d;
   logic [AW-1:0]       err_addr_q, err_addr_d;
   logic [DW-1:0]       err_data_q, err_data_d;

   logic [AW+DW-1:0]    mem_q [DEPTH];
   logic [AW+DW-1:0]    entry;
   logic                push;
   logic                exp_ready;

   assign exp_ready = (state_q == ST_LOAD) && (count_q < CW'(DEPTH));
   assign entry     = mem_q[rd_ptr_q[IW-1:0]];

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      match_cnt_d = match_cnt_q;
      timer_d     = timer_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      err_code_d  = err_code_q;
      err_pc_d    = err_pc_q;
      err_addr_d  = err_addr_q;
      err_data_d  = err_data_q;
      push        = 1'b0;

      case (state_q)
         ST_LOAD: begin
            if (exp_valid_i && exp_ready) begin
               push    = 1'b1;
               count_d = count_q + CW'(1);
            end
            // count_d already includes an entry pushed alongside start
            if (start_i) begin
               timer_d = '0;
               if (count_d == '0) begin
                  state_d = ST_PASS;
                  pass_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            if (memwrite_i) begin
               if ({dataaddr_i, writedata_i} == entry) begin
                  rd_ptr_d    = rd_ptr_q + CW'(1);
                  match_cnt_d = match_cnt_q + CW'(1);
                  timer_d     = '0;
                  if (rd_ptr_d == count_q) begin
                     state_d = ST_PASS;
                     pass_d  = 1'b1;
                  end
               end else begin
                  state_d    = ST_FAIL;
                  fail_d     = 1'b1;
                  err_code_d = ERR_MISMATCH;
                  err_pc_d   = pc_i;
                  err_addr_d = dataaddr_i;
                  err_data_d = writedata_i;
               end
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d    = ST_FAIL;
               fail_d     = 1'b1;
               err_code_d = ERR_TIMEOUT;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         ST_PASS: begin
            if (memwrite_i) begin
               state_d    = ST_FAIL;
               pass_d     = 1'b0;
               fail_d     = 1'b1;
               err_code_d = ERR_EXTRA;
               err_pc_d   = pc_i;
               err_addr_d = dataaddr_i;
               err_data_d = writedata_i;
            end
         end

         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_LOAD;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         match_cnt_q <= '0;
         timer_q     <= '0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         err_code_q  <= ERR_NONE;
         err_pc_q    <= '0;
         err_addr_q  <= '0;
         err_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         match_cnt_q <= match_cnt_d;
         timer_q     <= timer_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         err_code_q  <= err_code_d;
         err_pc_q    <= err_pc_d;
         err_addr_q  <= err_addr_d;
         err_data_q  <= err_data_d;
      end
   end

   // entry storage needs no reset: count_q bounds what is ever read
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[count_q[IW-1:0]] <= {exp_addr_i, exp_data_i};
      end
   end

   assign exp_ready_o = exp_ready;
   assign done_o      = pass_q | fail_q;
   assign pass_o      = pass_q;
   assign fail_o      = fail_q;
   assign err_code_o  = err_code_q;
   assign err_pc_o    = err_pc_q;
   assign err_addr_o  = err_addr_q;
   assign err_data_o  = err_data_q;
   assign match_cnt_o = match_cnt_q;

endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker: randomized and directed checks of store_checker against a
// list-based reference of the expected-store protocol.
module tb_store_checker;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 16;
   localparam int AW      = 32;
   localparam int DW      = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          memwrite = 1'b0;
   logic [AW-1:0] dataaddr = '0;
   logic [DW-1:0] writedata = '0;
   logic [31:0]   pc = '0;
   logic          exp_valid = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_data = '0;
   logic          exp_ready;
   logic          start = 1'b0;
   logic          done, pass, fail;
   logic [1:0]    err_code;
   logic [31:0]   err_pc;
   logic [AW-1:0] err_addr;
   logic [DW-1:0] err_data;
   logic [3:0]    match_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   store_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .AW(AW), .DW(DW)) dut (
      .clk_i(clk), .reset_i(reset), .memwrite_i(memwrite), .dataaddr_i(dataaddr),
      .writedata_i(writedata), .pc_i(pc), .exp_valid_i(exp_valid), .exp_addr_i(exp_addr),
      .exp_data_i(exp_data), .exp_ready_o(exp_ready), .start_i(start), .done_o(done),
      .pass_o(pass), .fail_o(fail), .err_code_o(err_code), .err_pc_o(err_pc),
      .err_addr_o(err_addr), .err_data_o(err_data), .match_cnt_o(match_cnt)
   );

   always #5 clk = ~clk;

   wire [9:0]  dut_st  = {done, pass, fail, err_code, match_cnt, exp_ready};
   wire [95:0] dut_err = {err_pc, err_addr, err_data};

   // reference: list of expected stores, how many were matched, cycles since last progress
   logic [AW+DW-1:0] m_list[$];
   bit          m_started = 0;
   int          m_matched = 0;
   int          m_idle    = 0;
   int          m_verdict = 0;   // 0 undecided, 1 pass, 2 fail
   logic [1:0]  m_code = 0;
   logic [95:0] m_err  = 0;

   function automatic logic [9:0] m_status();
      logic ready;
      ready = !m_started && (m_list.size() < DEPTH);
      return {m_verdict != 0, m_verdict == 1, m_verdict == 2, m_code, 4'(m_matched), ready};
   endfunction

   task automatic model_step();
      if (reset) begin
         m_list.delete();
         m_started = 0; m_matched = 0; m_idle = 0; m_verdict = 0; m_code = 0; m_err = 0;
      end else if (!m_started) begin
         if (exp_valid && m_list.size() < DEPTH) m_list.push_back({exp_addr, exp_data});
         if (start) begin
            m_started = 1;
            m_idle = 0;
            if (m_list.size() == 0) m_verdict = 1;
         end
      end else if (m_verdict == 1) begin
         if (memwrite) begin
            m_verdict = 2; m_code = 2; m_err = {pc, dataaddr, writedata};
         end
      end else if (m_verdict == 0) begin
         if (memwrite) begin
            if ({dataaddr, writedata} == m_list[m_matched]) begin
               m_matched++;
               m_idle = 0;
               if (m_matched == m_list.size()) m_verdict = 1;
            end else begin
               m_verdict = 2; m_code = 1; m_err = {pc, dataaddr, writedata};
            end
         end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               m_verdict = 2; m_code = 3;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic quiet();
      reset = 0; memwrite = 0; exp_valid = 0; start = 0;
   endtask

   task automatic do_reset();
      quiet(); reset = 1; tick(); reset = 0;
   endtask

   task automatic push_entry(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit with_start);
      exp_valid = 1; exp_addr = a; exp_data = d; start = with_start;
      tick();
      exp_valid = 0; start = 0;
   endtask

   task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [31:0] p);
      memwrite = 1; dataaddr = a; writedata = d; pc = p;
      tick();
      memwrite = 0;
   endtask

   task automatic test_reset();
      reset = 1; tick(); tick(); reset = 0;
      n_tests++;
      if (dut_st !== 10'b000_00_0000_1) begin
         n_fail++; $display("FAIL reset_state: got %h want %h", dut_st, 10'b000_00_0000_1);
      end
      n_tests++;
      if (dut_err !== '0) begin
         n_fail++; $display("FAIL reset_err: got %h want 0", dut_err);
      end
   endtask

   task automatic test_single_match();
      do_reset();
      push_entry(80, 12, 0);
      start = 1; tick(); start = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_tests++;
         if (dut_st !== m_status()) begin
            n_fail++; $display("FAIL single_wait%0d: got %h want %h", i, dut_st, m_status());
         end
      end
      store(80, 12, 32'h40);
      n_tests++;
      if ({pass, fail, err_code, match_cnt} !== {1'b1, 1'b0, 2'd0, 4'd1}) begin
         n_fail++; $display("FAIL single_pass: got %b%b %0d %0d want 10 0 1", pass, fail, err_code, match_cnt);
      end
   endtask

   task automatic test_extra_store();
      store(88, 5, 32'h44);
      n_tests++;
      if ({pass, fail, err_code, err_addr, err_data, err_pc} !== {1'b0, 1'b1, 2'd2, 32'd88, 32'd5, 32'h44}) begin
         n_fail++; $display("FAIL extra_store: got p%b f%b c%0d a%0d d%0d pc%h want p0 f1 c2 a88 d5 pc44",
                            pass, fail, err_code, err_addr, err_data, err_pc);
      end
      store(80, 12, 32'h48);
      n_tests++;
      if ({dut_st, dut_err} !== {m_status(), m_err}) begin
         n_fail++; $display("FAIL fail_frozen: got %h/%h want %h/%h", dut_st, dut_err, m_status(), m_err);
      end
   endtask

   task automatic test_mismatch();
      do_reset();
      push_entry(80, 12, 0);
      start = 1; tick(); start = 0;
      tick();
      store(84, 12, 32'h10);
      n_tests++;
      if ({fail, err_code, err_addr, err_data, err_pc, match_cnt} !== {1'b1, 2'd1, 32'd84, 32'd12, 32'h10, 4'd0}) begin
         n_fail++; $display("FAIL mismatch_store: got f%b c%0d a%0d d%0d pc%h m%0d want f1 c1 a84 d12 pc10 m0",
                            fail, err_code, err_addr, err_data, err_pc, match_cnt);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      push_entry(80, 12, 0);
      start = 1; tick(); start = 0;
      for (int i = 1; i <= TIMEOUT; i++) begin
         tick();
         n_tests++;
         if (fail !== (i == TIMEOUT)) begin
            n_fail++; $display("FAIL timeout_cycle%0d: got fail=%b want %b", i, fail, i == TIMEOUT);
         end
      end
      n_tests++;
      if ({err_code, dut_err} !== {2'd3, 96'd0}) begin
         n_fail++; $display("FAIL timeout_err: got c%0d err=%h want c3 err=0", err_code, dut_err);
      end
   endtask

   task automatic test_overflow();
      logic [AW+DW-1:0] ents[9];
      do_reset();
      for (int i = 0; i < 9; i++) begin
         ents[i] = {$urandom, $urandom};
         push_entry(ents[i][AW+DW-1:DW], ents[i][DW-1:0], 0);
         n_tests++;
         if (exp_ready !== (i < 7)) begin
            n_fail++; $display("FAIL overflow_ready%0d: got %b want %b", i, exp_ready, i < 7);
         end
      end
      start = 1; tick(); start = 0;
      for (int i = 0; i < 8; i++) begin
         int gap;
         gap = $urandom_range(0, 5);
         for (int g = 0; g < gap; g++) tick();
         store(ents[i][AW+DW-1:DW], ents[i][DW-1:0], $urandom);
         n_tests++;
         if (dut_st !== m_status()) begin
            n_fail++; $display("FAIL overflow_store%0d: got %h want %h", i, dut_st, m_status());
         end
      end
      n_tests++;
      if ({pass, match_cnt} !== {1'b1, 4'd8}) begin
         n_fail++; $display("FAIL overflow_pass: got p%b m%0d want p1 m8", pass, match_cnt);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [AW+DW-1:0] ents[3];
      do_reset();
      for (int i = 0; i < 3; i++) begin
         ents[i] = {$urandom, $urandom};
         push_entry(ents[i][AW+DW-1:DW], ents[i][DW-1:0], 0);
      end
      start = 1; tick(); start = 0;
      store(ents[0][AW+DW-1:DW], ents[0][DW-1:0], 0);
      reset = 1; tick(); reset = 0;
      n_tests++;
      if ({exp_ready, match_cnt, pass, fail} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL midrun_reset: got r%b m%0d p%b f%b want r1 m0 p0 f0", exp_ready, match_cnt, pass, fail);
      end
      for (int i = 0; i < 3; i++) push_entry(ents[i][AW+DW-1:DW], ents[i][DW-1:0], i == 2);
      for (int i = 0; i < 3; i++) store(ents[i][AW+DW-1:DW], ents[i][DW-1:0], 0);
      n_tests++;
      if ({pass, match_cnt} !== {1'b1, 4'd3}) begin
         n_fail++; $display("FAIL midrun_replay: got p%b m%0d want p1 m3", pass, match_cnt);
      end
   endtask

   task automatic test_start_edges();
      do_reset();
      start = 1; tick(); start = 0;
      n_tests++;
      if ({pass, fail, done} !== 3'b101) begin
         n_fail++; $display("FAIL empty_start: got p%b f%b d%b want 101", pass, fail, done);
      end
      do_reset();
      push_entry(16, 1, 0);
      push_entry(20, 2, 1);
      store(16, 1, 0);
      store(20, 2, 0);
      n_tests++;
      if ({pass, match_cnt} !== {1'b1, 4'd2}) begin
         n_fail++; $display("FAIL start_with_push: got p%b m%0d want p1 m2", pass, match_cnt);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 25; r++) begin
         int n;
         do_reset();
         n = $urandom_range(1, DEPTH + 1);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            push_entry($urandom_range(0, 3) * 4, $urandom_range(0, 3), (i == n - 1) && ($urandom_range(0, 1) == 1));
         end
         if (!m_started) begin
            start = 1; tick(); start = 0;
         end
         for (int c = 0; c < 40; c++) begin
            int k;
            k = $urandom_range(0, 19);
            exp_valid = ($urandom_range(0, 7) == 0);
            start     = ($urandom_range(0, 7) == 0);
            if (k < 11 && m_matched < m_list.size()) begin
               memwrite = 1; pc = $urandom;
               {dataaddr, writedata} = m_list[m_matched];
               if (k == 0) writedata = writedata ^ 32'h1;
            end else if (k == 11) begin
               memwrite = 1; pc = $urandom;
               dataaddr = $urandom_range(0, 3) * 4; writedata = $urandom_range(0, 3);
            end
            tick();
            quiet();
            n_tests++;
            if ({dut_st, dut_err} !== {m_status(), m_err}) begin
               n_fail++; $display("FAIL random_r%0d_c%0d: got %h/%h want %h/%h", r, c, dut_st, dut_err, m_status(), m_err);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_match();
      test_extra_store();
      test_mismatch();
      test_timeout();
      test_overflow();
      test_reset_mid_run();
      test_start_edges();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
